datamem_mc: RTL
===============

Name: datamem_mc

Overview:
Parametrised multi-channel data memory for the systolic array.
- One synchronous write port and NUM_RD independent registered read channels, one per array row/column feeder.
- Hardware clear sweep after reset and on request, so contents are defined without file preload.
- Same-cycle write/read bypass.
- Sits between the load/store controller and the array edge buffers.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 8, address width; depth DEPTH = 2**ADDR_W words (256 default)
NUM_RD, 4, number of read channels

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
clr  in  1  single-cycle request to re-run the clear sweep
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_req  in  NUM_RD  per-channel read request
rd_addr  in  NUM_RD*ADDR_W  channel i address at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  channel i data at [i*DATA_W +: DATA_W]
rd_valid  out  NUM_RD  per-channel data-valid strobe
init_busy  out  1  high while the clear sweep runs
par_err  out  NUM_RD  per-channel parity error, qualified by rd_valid

Behaviour:
- Reset (rst_n=0, async):
  - state=ST_INIT, sweep counter=0.
  - rd_data=0, rd_valid=0, par_err=0, init_busy=1.
  - Array storage itself is not reset.
- ST_INIT:
  - Each cycle writes 0 (parity 0) to MEM[cnt], then cnt+1.
  - After the cycle writing DEPTH-1, go to ST_IDLE. Sweep lasts exactly DEPTH cycles after rst_n rises.
  - wr_en ignored (write dropped). rd_req ignored (rd_valid stays 0).
  - clr during ST_INIT restarts cnt at 0.
- ST_IDLE:
  - clr=1 -> ST_INIT, cnt=0, init_busy=1 from the next cycle.
  - clr takes priority over a same-cycle wr_en; that write is dropped.
  - Reads are still served on the clr cycle.
- init_busy is registered: init_busy = (state==ST_INIT).
- Write: at posedge with wr_en=1 in ST_IDLE, MEM[wr_addr] <= wr_data.
- Read, per channel i, latency 1:
  - rd_req[i]=1 at edge N -> rd_data[i]=MEM[rd_addr[i]] and rd_valid[i]=1 after edge N+1.
  - rd_valid[i] is 0 in any cycle following no request.
  - rd_data[i] holds its last value when there is no request.
- Collision (write-first): if wr_en and wr_addr==rd_addr[i] in the same cycle, rd_data[i] returns wr_data.
  - Any number of channels may read the same address simultaneously.
- No out-of-range addresses exist (full 2**ADDR_W decode). No back-pressure; channels are always ready.

Optional Feature:
DATAMEM_PARITY_EN
- Defined:
  - Storage is DATA_W+1 bits; stored bit DATA_W = ^wr_data.
  - On a read, par_err[i] is registered alongside rd_valid[i] as (^data != stored parity).
  - Bypassed reads always have par_err=0.
- Undefined: storage is DATA_W bits; par_err tied to 0.
- Ports are identical in both builds.

Decomposition:
- Package datamem_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - typedef enum mem_state_t {ST_INIT, ST_IDLE}.
- Sub-module datamem_rd_port: one per channel via a generate loop. Contains registered rd_data/rd_valid, bypass mux and parity check.
- The top level owns the array, FSM, sweep counter and write port.

Test Plan:
- Reset/sweep: rst_n=0 for 5 cycles, release -> init_busy=1 for exactly 256 cycles, then 0. Read ch0 addr 0x3F -> rd_data=0x0000, rd_valid=1 next cycle.
- Basic R/W: write 0xBEEF@0x10, next cycle rd_req[2] addr 0x10 -> rd_data[2]=0xBEEF, rd_valid[2]=1 one cycle later. Other rd_valid bits stay 0.
- Collision: wr 0x1234@0x20 plus rd_req=4'b1111 all at 0x20 in the same cycle -> all four channels return 0x1234 next cycle.
- Blocked during sweep: wr 0xAAAA@0x05 and rd_req[1] at sweep cycle 10 -> rd_valid stays 0. After sweep, read 0x05 -> 0x0000.
- clr/reset mid-operation:
  - Fill 0x00-0x0F with 0x0100+addr, pulse clr with a same-cycle write 0x5555@0x30 -> init_busy 256 cycles, then all reads (incl. 0x30) return 0.
  - rst_n low at sweep cycle 100 -> sweep restarts; init_busy high for 256 cycles after release.
- DATAMEM_PARITY_EN: write 0x0001@0x40, force-flip stored parity bit, read -> rd_valid=1, par_err=1. Unflipped read -> par_err=0. Build without macro -> par_err always 0.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared constants and state type for the multi-channel data memory.
package datamem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int NUM_RD_DEF = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } mem_state_t;

endpackage

// File: rtl/datamem_rd_port.sv
// One registered read channel: write-first bypass mux, valid strobe and optional parity check.
// Parity checking is built only when DATAMEM_PARITY_EN is defined.
module datamem_rd_port #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              byp_hit,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
`ifdef DATAMEM_PARITY_EN
    input  logic              mem_par,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              par_err
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_data_d = byp_hit ? wr_data : mem_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

`ifdef DATAMEM_PARITY_EN
    logic par_err_q, par_err_d;

    // A bypassed word never touched the array, so it cannot carry a parity fault.
    always_comb begin
        par_err_d = 1'b0;
        if (rd_en && !byp_hit) begin
            par_err_d = ((^mem_data) != mem_par);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/datamem_mc.sv
// Multi-channel data memory: one write port, NUM_RD registered read channels, hardware clear sweep.
// Define DATAMEM_PARITY_EN to store and check a per-word even parity bit.
module datamem_mc
    import datamem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     init_busy,
    output logic [NUM_RD-1:0]        par_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DATAMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem [DEPTH];

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_busy_q, init_busy_d;

    logic              mem_we;
    logic              wr_fire;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  wr_word;

`ifdef DATAMEM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        wr_fire   = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_word;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // clr wins over a same-cycle write, which is dropped.
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (wr_en) begin
                    mem_we  = 1'b1;
                    wr_fire = 1'b1;
                end
            end
        endcase
        init_busy_d = (state_d == ST_INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // NOTE: the array has no reset; the clear sweep defines its contents instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign init_busy = init_busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_i;
        logic [MEM_W-1:0]  word_i;

        assign addr_i = rd_addr[i*ADDR_W +: ADDR_W];
        assign word_i = mem[addr_i];

        datamem_rd_port #(
            .DATA_W (DATA_W)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_req[i] && (state_q == ST_IDLE)),
            .byp_hit  (wr_fire && (wr_addr == addr_i)),
            .wr_data  (wr_data),
            .mem_data (word_i[DATA_W-1:0]),
`ifdef DATAMEM_PARITY_EN
            .mem_par  (word_i[DATA_W]),
`endif
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_valid (rd_valid[i]),
            .par_err  (par_err[i])
        );
    end

endmodule
